// File: rtl/uart_pkg.sv
// Shared UART types and sizing helpers for the receive, transmit and flow-control blocks.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for an idle-high asynchronous line; resets to 1 so no false start is seen.
module uart_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_axis_packer.sv
// UART receiver that packs W_OUT/BITS_PER_WORD good characters into one AXI-Stream beat,
// reporting parity, framing and overrun errors as single-cycle pulses.
module uart_rx_axis_packer #(
    parameter int unsigned CLOCKS_PER_PULSE = 16,
    parameter int unsigned BITS_PER_WORD    = 8,
    parameter int unsigned W_OUT            = 16,
    parameter int unsigned PARITY           = 0,
    parameter int unsigned STOP_BITS        = 1,
    parameter int unsigned SYNC_STAGES      = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             rx,
    input  logic             m_ready,
    output logic             m_valid,
    output logic [W_OUT-1:0] m_data,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun
);

    import uart_pkg::*;

    localparam int unsigned NUM_WORDS = W_OUT / BITS_PER_WORD;
    localparam int unsigned CLK_W     = cnt_w(CLOCKS_PER_PULSE);
    localparam int unsigned BIT_W     = cnt_w((BITS_PER_WORD > STOP_BITS) ? BITS_PER_WORD : STOP_BITS);
    localparam int unsigned WORD_W    = cnt_w(NUM_WORDS);
    localparam int unsigned HALF      = CLOCKS_PER_PULSE / 2 - 1;
    localparam int unsigned FULL      = CLOCKS_PER_PULSE - 1;
    localparam parity_e     PAR_MODE  = parity_e'(2'(PARITY));

    logic                     rx_s;
    rx_state_e                state_q, state_d;
    logic [CLK_W-1:0]         c_clk_q, c_clk_d;
    logic [BIT_W-1:0]         c_bit_q, c_bit_d;
    logic [WORD_W-1:0]        c_word_q, c_word_d;
    logic [BITS_PER_WORD-1:0] shift_q, shift_d;
    logic                     par_bad_q, par_bad_d;
    logic                     frm_bad_q, frm_bad_d;
    logic                     done_q, done_d;
    logic [W_OUT-1:0]         pack_q, pack_d;
    logic                     m_valid_q, m_valid_d;
    logic [W_OUT-1:0]         m_data_q, m_data_d;
    logic                     parity_err_q, parity_err_d;
    logic                     frame_err_q, frame_err_d;
    logic                     overrun_q, overrun_d;
    logic                     pkt_done_c;
    logic                     centre_c;

    uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (rx),
        .q    (rx_s)
    );

    assign centre_c = (c_clk_q == CLK_W'(FULL));

    // Frame FSM, character completion and output beat handling.
    always_comb begin
        state_d      = state_q;
        c_clk_d      = c_clk_q;
        c_bit_d      = c_bit_q;
        c_word_d     = c_word_q;
        shift_d      = shift_q;
        par_bad_d    = par_bad_q;
        frm_bad_d    = frm_bad_q;
        done_d       = 1'b0;
        pack_d       = pack_q;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
        pkt_done_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    c_clk_d = '0;
                end
            end
            START: begin
                if (c_clk_q == CLK_W'(HALF)) begin
                    c_clk_d   = '0;
                    c_bit_d   = '0;
                    par_bad_d = 1'b0;
                    frm_bad_d = 1'b0;
                    state_d   = rx_s ? IDLE : DATA;
                end else begin
                    c_clk_d = c_clk_q + CLK_W'(1);
                end
            end
            DATA: begin
                if (centre_c) begin
                    c_clk_d = '0;
                    shift_d = {rx_s, shift_q[BITS_PER_WORD-1:1]};
                    if (c_bit_q == BIT_W'(BITS_PER_WORD - 1)) begin
                        c_bit_d = '0;
                        state_d = (PAR_MODE == PAR_NONE) ? STOP : uart_pkg::PARITY;
                    end else begin
                        c_bit_d = c_bit_q + BIT_W'(1);
                    end
                end else begin
                    c_clk_d = c_clk_q + CLK_W'(1);
                end
            end
            uart_pkg::PARITY: begin
                if (centre_c) begin
                    c_clk_d   = '0;
                    par_bad_d = (PAR_MODE == PAR_ODD) ? ~(^shift_q ^ rx_s) : (^shift_q ^ rx_s);
                    state_d   = STOP;
                end else begin
                    c_clk_d = c_clk_q + CLK_W'(1);
                end
            end
            STOP: begin
                if (centre_c) begin
                    c_clk_d   = '0;
                    frm_bad_d = frm_bad_q | ~rx_s;
                    if (c_bit_q == BIT_W'(STOP_BITS - 1)) begin
                        c_bit_d = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        c_bit_d = c_bit_q + BIT_W'(1);
                    end
                end else begin
                    c_clk_d = c_clk_q + CLK_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A bad character throws away the whole partial packet.
        if (done_q) begin
            if (frm_bad_q) begin
                frame_err_d = 1'b1;
                c_word_d    = '0;
                pack_d      = '0;
            end else if (par_bad_q) begin
                parity_err_d = 1'b1;
                c_word_d     = '0;
                pack_d       = '0;
            end else begin
                pack_d[32'(c_word_q) * BITS_PER_WORD +: BITS_PER_WORD] = shift_q;
                if (c_word_q == WORD_W'(NUM_WORDS - 1)) begin
                    pkt_done_c = 1'b1;
                    c_word_d   = '0;
                end else begin
                    c_word_d = c_word_q + WORD_W'(1);
                end
            end
        end

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
        if (pkt_done_c) begin
            if (m_valid_q && !m_ready) begin
                overrun_d = 1'b1;
            end else begin
                m_valid_d = 1'b1;
                m_data_d  = pack_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            c_clk_q      <= '0;
            c_bit_q      <= '0;
            c_word_q     <= '0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            frm_bad_q    <= 1'b0;
            done_q       <= 1'b0;
            pack_q       <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            c_clk_q      <= c_clk_d;
            c_bit_q      <= c_bit_d;
            c_word_q     <= c_word_d;
            shift_q      <= shift_d;
            par_bad_q    <= par_bad_d;
            frm_bad_q    <= frm_bad_d;
            done_q       <= done_d;
            pack_q       <= pack_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_axis_packer.sv
// Bench for uart_rx_axis_packer: a default instance and an even-parity instance, scoreboarded beats.
module tb_uart_rx_axis_packer;

    localparam int CPP = 16;

    logic        clk = 1'b0;
    logic        rstn;
    logic        rx_a, rx_b, m_ready_a, m_ready_b;
    logic        m_valid_a, m_valid_b;
    logic [15:0] m_data_a, m_data_b;
    logic        perr_a, ferr_a, ovr_a, perr_b, ferr_b, ovr_b;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int n_perr_a = 0, n_ferr_a = 0, n_ovr_a = 0;
    int n_perr_b = 0, n_ferr_b = 0, n_ovr_b = 0;
    logic [15:0] q_a[$];
    logic [15:0] q_b[$];

    always #5 clk = ~clk;

    uart_rx_axis_packer dut_a (
        .clk(clk), .rstn(rstn), .rx(rx_a), .m_ready(m_ready_a),
        .m_valid(m_valid_a), .m_data(m_data_a),
        .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a)
    );

    uart_rx_axis_packer #(.PARITY(2)) dut_b (
        .clk(clk), .rstn(rstn), .rx(rx_b), .m_ready(m_ready_b),
        .m_valid(m_valid_b), .m_data(m_data_b),
        .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b)
    );

    // Beat monitors: every handshake pops and compares one expected packet.
    always @(negedge clk) begin : mon_a
        logic [15:0] e;
        if (rstn) begin
            if (perr_a) n_perr_a++;
            if (ferr_a) n_ferr_a++;
            if (ovr_a)  n_ovr_a++;
            if (m_valid_a && m_ready_a) begin
                chk_cnt++;
                if (q_a.size() == 0) begin
                    $display("FAIL beat_a unexpected beat data=%h", m_data_a);
                end else begin
                    e = q_a.pop_front();
                    if (m_data_a !== e) $display("FAIL beat_a data got=%h exp=%h", m_data_a, e);
                    else pass_cnt++;
                end
            end
        end
    end

    always @(negedge clk) begin : mon_b
        logic [15:0] e;
        if (rstn) begin
            if (perr_b) n_perr_b++;
            if (ferr_b) n_ferr_b++;
            if (ovr_b)  n_ovr_b++;
            if (m_valid_b && m_ready_b) begin
                chk_cnt++;
                if (q_b.size() == 0) begin
                    $display("FAIL beat_b unexpected beat data=%h", m_data_b);
                end else begin
                    e = q_b.pop_front();
                    if (m_data_b !== e) $display("FAIL beat_b data got=%h exp=%h", m_data_b, e);
                    else pass_cnt++;
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic drive_bits(input int which, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (which == 0) rx_a = bits[i];
            else            rx_b = bits[i];
            repeat (CPP) @(negedge clk);
        end
    endtask

    task automatic send_a(input logic [7:0] d, input logic stop);
        drive_bits(0, {6'b0, stop, d, 1'b0}, 10);
        rx_a = 1'b1;
    endtask

    task automatic send_b(input logic [7:0] d, input logic p);
        drive_bits(1, {5'b0, 1'b1, p, d, 1'b0}, 11);
        rx_b = 1'b1;
    endtask

    task automatic idle(input int cycles);
        rx_a = 1'b1;
        rx_b = 1'b1;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic wait_drain(input int which, input string name);
        int t;
        int sz;
        t  = 0;
        sz = (which == 0) ? q_a.size() : q_b.size();
        while (sz != 0 && t < 100) begin
            @(negedge clk);
            #1;
            t++;
            sz = (which == 0) ? q_a.size() : q_b.size();
        end
        chk_cnt++;
        if (sz != 0) $display("FAIL %s beat timeout pending=%0d exp=0", name, sz);
        else         pass_cnt++;
    endtask

    task automatic test_reset();
        rstn = 1'b0; rx_a = 1'b1; rx_b = 1'b1; m_ready_a = 1'b1; m_ready_b = 1'b1;
        repeat (3) @(negedge clk);
        chk_cnt++; if (m_valid_a !== 1'b0) $display("FAIL reset_valid_a got=%b exp=0", m_valid_a); else pass_cnt++;
        chk_cnt++; if (m_data_a !== 16'h0) $display("FAIL reset_data_a got=%h exp=0000", m_data_a); else pass_cnt++;
        chk_cnt++; if ({perr_a, ferr_a, ovr_a} !== 3'b000) $display("FAIL reset_err_a got=%b exp=000", {perr_a, ferr_a, ovr_a}); else pass_cnt++;
        chk_cnt++; if (m_valid_b !== 1'b0) $display("FAIL reset_valid_b got=%b exp=0", m_valid_b); else pass_cnt++;
        chk_cnt++; if ({perr_b, ferr_b, ovr_b} !== 3'b000) $display("FAIL reset_err_b got=%b exp=000", {perr_b, ferr_b, ovr_b}); else pass_cnt++;
        rstn = 1'b1;
        idle(2 * CPP);
    endtask

    task automatic test_basic();
        int base;
        base = n_perr_a + n_ferr_a + n_ovr_a;
        q_a.push_back(16'h3CA5);
        send_a(8'hA5, 1'b1);
        send_a(8'h3C, 1'b1);
        wait_drain(0, "basic");
        @(negedge clk);
        chk_cnt++; if (m_valid_a !== 1'b0) $display("FAIL basic_valid_drop got=%b exp=0", m_valid_a); else pass_cnt++;
        idle(2 * CPP);
        chk_cnt++; if (n_perr_a + n_ferr_a + n_ovr_a != base) $display("FAIL basic_errors got=%0d exp=%0d", n_perr_a + n_ferr_a + n_ovr_a, base); else pass_cnt++;
    endtask

    task automatic test_parity();
        int bp, bf;
        bp = n_perr_b; bf = n_ferr_b;
        q_b.push_back(16'h2211);
        send_b(8'hA5, 1'b1);
        send_b(8'h11, 1'b0);
        send_b(8'h22, 1'b0);
        wait_drain(1, "parity");
        idle(2 * CPP);
        chk_cnt++; if (n_perr_b - bp != 1) $display("FAIL parity_pulses got=%0d exp=1", n_perr_b - bp); else pass_cnt++;
        chk_cnt++; if (n_ferr_b - bf != 0) $display("FAIL parity_frame got=%0d exp=0", n_ferr_b - bf); else pass_cnt++;
    endtask

    task automatic test_frame();
        int bf;
        bf = n_ferr_a;
        send_a(8'h55, 1'b0);
        idle(3 * CPP);
        chk_cnt++; if (n_ferr_a - bf != 1) $display("FAIL frame_pulses got=%0d exp=1", n_ferr_a - bf); else pass_cnt++;
        chk_cnt++; if (m_valid_a !== 1'b0) $display("FAIL frame_no_beat got=%b exp=0", m_valid_a); else pass_cnt++;
        q_a.push_back(16'h0201);
        send_a(8'h01, 1'b1);
        send_a(8'h02, 1'b1);
        wait_drain(0, "frame_recover");
        idle(2 * CPP);
    endtask

    task automatic test_overrun();
        int bo;
        bo = n_ovr_a;
        m_ready_a = 1'b0;
        q_a.push_back(16'h0201);
        send_a(8'h01, 1'b1);
        send_a(8'h02, 1'b1);
        send_a(8'h03, 1'b1);
        send_a(8'h04, 1'b1);
        idle(2 * CPP);
        chk_cnt++; if (m_valid_a !== 1'b1) $display("FAIL overrun_valid got=%b exp=1", m_valid_a); else pass_cnt++;
        chk_cnt++; if (m_data_a !== 16'h0201) $display("FAIL overrun_held got=%h exp=0201", m_data_a); else pass_cnt++;
        chk_cnt++; if (n_ovr_a - bo != 1) $display("FAIL overrun_pulses got=%0d exp=1", n_ovr_a - bo); else pass_cnt++;
        m_ready_a = 1'b1;
        wait_drain(0, "overrun_accept");
        @(negedge clk);
        chk_cnt++; if (m_valid_a !== 1'b0) $display("FAIL overrun_clear got=%b exp=0", m_valid_a); else pass_cnt++;
        idle(2 * CPP);
    endtask

    task automatic test_false_start();
        int base;
        base = n_perr_a + n_ferr_a + n_ovr_a;
        rx_a = 1'b0;
        repeat (3) @(negedge clk);
        idle(3 * CPP);
        chk_cnt++; if (m_valid_a !== 1'b0) $display("FAIL false_start_beat got=%b exp=0", m_valid_a); else pass_cnt++;
        chk_cnt++; if (n_perr_a + n_ferr_a + n_ovr_a != base) $display("FAIL false_start_err got=%0d exp=%0d", n_perr_a + n_ferr_a + n_ovr_a, base); else pass_cnt++;
        q_a.push_back(16'h3412);
        send_a(8'h12, 1'b1);
        send_a(8'h34, 1'b1);
        wait_drain(0, "false_start_recover");
        idle(2 * CPP);
    endtask

    task automatic test_reset_mid();
        send_a(8'hAA, 1'b1);
        drive_bits(0, {6'b0, 1'b1, 8'h77, 1'b0}, 4);
        rstn = 1'b0;
        rx_a = 1'b1;
        repeat (3) @(negedge clk);
        chk_cnt++; if (m_valid_a !== 1'b0) $display("FAIL midreset_valid got=%b exp=0", m_valid_a); else pass_cnt++;
        chk_cnt++; if (m_data_a !== 16'h0) $display("FAIL midreset_data got=%h exp=0000", m_data_a); else pass_cnt++;
        rstn = 1'b1;
        idle(2 * CPP);
        q_a.push_back(16'hBBAA);
        send_a(8'hAA, 1'b1);
        send_a(8'hBB, 1'b1);
        wait_drain(0, "midreset_recover");
        idle(2 * CPP);
    endtask

    initial begin
        rstn = 1'b0;
        rx_a = 1'b1; rx_b = 1'b1;
        m_ready_a = 1'b1; m_ready_b = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_parity();
        test_frame();
        test_overrun();
        test_false_start();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/uart_rx_axis_packer.md
Name: uart_rx_axis_packer

Overview:
- Parametrised UART receiver that packs NUM_WORDS = W_OUT/BITS_PER_WORD serial characters into one AXI-Stream beat.
- Adds over the previous-generation receiver: rx synchroniser, false-start rejection, optional parity, 1 or 2 stop bits, framing and parity error reporting, and m_ready backpressure with overrun detection.
- Sits between the board rx pin and any AXI-Stream sink in the UART subsystem.

Parameters:
- CLOCKS_PER_PULSE, 16, clk cycles per bit period; even, >= 4.
- BITS_PER_WORD, 8, data bits per character, 5..9.
- W_OUT, 16, m_data width; integer multiple of BITS_PER_WORD.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, 1 or 2.
- SYNC_STAGES, 2, rx synchroniser depth, >= 2.

Ports:
- clk  in  1  system clock
- rstn  in  1  reset; one clock; reset is asynchronous and active-low
- rx  in  1  asynchronous serial input, idle high
- m_ready  in  1  AXI-Stream ready from sink
- m_valid  out  1  AXI-Stream valid
- m_data  out  W_OUT  packed characters; first received character in bits [BITS_PER_WORD-1:0]
- parity_err  out  1  one-cycle pulse: parity mismatch
- frame_err  out  1  one-cycle pulse: a stop bit sampled 0
- overrun  out  1  one-cycle pulse: completed packet dropped because the output was still held

Behaviour:
- Reset: m_valid = 0, m_data = 0, all error pulses = 0, synchroniser flops = 1, state = IDLE, all counters = 0. Reset mid-frame abandons the frame and the partial packet.
- rx passes through SYNC_STAGES flops; rx_s below is the synchronised value.
- c_clk counts bit-period cycles, c_bit counts data bits, c_word counts characters in the packet.
- IDLE: rx_s == 0 -> START, c_clk = 0.
- START: at c_clk == CLOCKS_PER_PULSE/2-1, sample rx_s:
  - 1 -> false start, back to IDLE with no output.
  - 0 -> DATA, c_clk = 0.
- DATA: sample at each c_clk == CLOCKS_PER_PULSE-1 (bit centre), LSB first, into a shift register.
  - After BITS_PER_WORD samples -> PARITY if PARITY != 0, else STOP.
- PARITY: sample at bit centre.
  - Odd: XOR of data bits and parity bit must be 1. Even: must be 0.
  - On mismatch, flag the character bad and go to STOP.
- STOP: sample each of STOP_BITS centres. Any 0 flags a framing error.
  - After the last stop sample, go straight to IDLE, so back-to-back frames are received.
- Character completion, evaluated in the cycle after the last stop sample:
  - Framing error: frame_err = 1, character and partial packet discarded, c_word = 0.
  - Parity error only: parity_err = 1, same discard.
  - Both errors: only frame_err pulses.
  - Good character: written into slot c_word of the packing register; c_word increments.
  - When c_word reaches NUM_WORDS-1 the packet is complete and c_word wraps to 0.
- Output register:
  - A complete packet loads into m_data and sets m_valid = 1 in the same completion cycle.
  - Latency: m_valid rises SYNC_STAGES+1 cycles after the rx edge that ends the last stop-bit centre.
  - m_valid holds and m_data stays stable until the cycle where m_valid && m_ready; then m_valid clears.
  - Completion while m_valid && !m_ready: overrun = 1, new packet dropped, held beat unchanged.
  - Completion in the same cycle as m_valid && m_ready: new packet loads, m_valid stays 1, no overrun.
- Receiver never stalls on backpressure; rx sampling continues.

Decomposition:
- Package uart_pkg:
  - parity_e {PAR_NONE, PAR_ODD, PAR_EVEN}
  - rx_state_e {IDLE, START, DATA, PARITY, STOP}
  - helper constant function for counter widths ($clog2 with minimum 1)
- One natural sub-module: uart_sync, a SYNC_STAGES flop chain with asynchronous set-to-1 reset. Reused by the TX/flow-control blocks.

Test Plan:
- Defaults, m_ready = 1; send 0xA5 then 0x3C -> one beat, m_data = 0x3CA5, m_valid high one cycle, no error pulses.
- PARITY = 2; send 0xA5 with parity bit 1 (wrong), then 0x11 and 0x22 -> one parity_err pulse, then a single beat m_data = 0x2211.
- Send 0x55 with stop bit 0 -> frame_err pulse, no beat; next 0x01 and 0x02 -> m_data = 0x0201.
- m_ready = 0; send 0x01, 0x02, 0x03, 0x04 -> m_valid = 1 with m_data = 0x0201 held, overrun pulse after the fourth character; raise m_ready -> beat accepted, m_valid = 0.
- Pulse rx low for 3 clk cycles (less than half a bit period) -> no state change beyond START, no beat, no errors.
- Assert rstn low mid-DATA of the second character, release, send 0xAA and 0xBB -> m_data = 0xBBAA; no stale partial character.
